// File: rtl/parsed_msg_fifo.sv
// Record FIFO between the non-stallable ITCH parser and the order-book stage.
// First-word fall-through with a registered head copy; overflowing records are dropped and counted.
module parsed_msg_fifo #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [3:0]               in_type,
    input  logic [63:0]              in_order_ref,
    input  logic                     in_side,
    input  logic [31:0]              in_shares,
    input  logic [31:0]              in_price,
    input  logic [63:0]              in_new_ref,
    input  logic [47:0]              in_timestamp,
    input  logic [63:0]              in_misc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               out_type,
    output logic [63:0]              out_order_ref,
    output logic                     out_side,
    output logic [31:0]              out_shares,
    output logic [31:0]              out_price,
    output logic [63:0]              out_new_ref,
    output logic [47:0]              out_timestamp,
    output logic [63:0]              out_misc,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     full,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int REC_W = 309;
    localparam logic [AW:0] OCC_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] OCC_ONE  = (AW + 1)'(1);

    logic [REC_W-1:0] r_mem [DEPTH];
    logic [REC_W-1:0] r_head;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_occ;
    logic             r_overflow;
    logic [CNT_W-1:0] r_drop_cnt;

    logic [REC_W-1:0] w_in_rec;
    logic [AW-1:0]    w_rd_next;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    assign w_in_rec  = {in_type, in_order_ref, in_side, in_shares, in_price,
                        in_new_ref, in_timestamp, in_misc};
    assign w_rd_next = r_rd_ptr + AW'(1);
    assign w_empty   = (r_occ == '0);
    assign w_full    = (r_occ == OCC_FULL);
    assign w_pop     = ~w_empty & out_ready;
    assign w_push    = in_valid & (~w_full | w_pop);
    assign w_drop    = in_valid & w_full & ~w_pop;

    // Record storage; contents are never visible until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_rec;
        end
    end

    // Pointers and occupancy counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_ONE;
                2'b01:   r_occ <= r_occ - OCC_ONE;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Head copy: when the only stored record leaves while a new one arrives,
    // the successor is the incoming record, not yet readable from the array.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
        end else if (w_push && (w_empty || (w_pop && r_occ == OCC_ONE))) begin
            r_head <= w_in_rec;
        end else if (w_pop && r_occ > OCC_ONE) begin
            r_head <= r_mem[w_rd_next];
        end else begin
            r_head <= r_head;
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != {CNT_W{1'b1}}) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end else begin
                r_drop_cnt <= r_drop_cnt;
            end
        end else begin
            r_overflow <= r_overflow;
            r_drop_cnt <= r_drop_cnt;
        end
    end

    assign out_valid     = ~w_empty;
    assign full          = w_full;
    assign occupancy     = r_occ;
    assign overflow      = r_overflow;
    assign drop_count    = r_drop_cnt;
    assign out_type      = r_head[308:305];
    assign out_order_ref = r_head[304:241];
    assign out_side      = r_head[240];
    assign out_shares    = r_head[239:208];
    assign out_price     = r_head[207:176];
    assign out_new_ref   = r_head[175:112];
    assign out_timestamp = r_head[111:64];
    assign out_misc      = r_head[63:0];

endmodule

// File: tb/tb_parsed_msg_fifo.sv
// Directed self-checking bench for parsed_msg_fifo (DEPTH=16, CNT_W=16).
module tb_parsed_msg_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  in_type;
    logic [63:0] in_order_ref;
    logic        in_side;
    logic [31:0] in_shares;
    logic [31:0] in_price;
    logic [63:0] in_new_ref;
    logic [47:0] in_timestamp;
    logic [63:0] in_misc;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_type;
    logic [63:0] out_order_ref;
    logic        out_side;
    logic [31:0] out_shares;
    logic [31:0] out_price;
    logic [63:0] out_new_ref;
    logic [47:0] out_timestamp;
    logic [63:0] out_misc;
    logic [4:0]  occupancy;
    logic        full;
    logic        overflow;
    logic [15:0] drop_count;

    int n_checks = 0;
    int n_errors = 0;

    parsed_msg_fifo #(.DEPTH(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_type(in_type), .in_order_ref(in_order_ref),
        .in_side(in_side), .in_shares(in_shares), .in_price(in_price),
        .in_new_ref(in_new_ref), .in_timestamp(in_timestamp), .in_misc(in_misc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_type(out_type), .out_order_ref(out_order_ref), .out_side(out_side),
        .out_shares(out_shares), .out_price(out_price), .out_new_ref(out_new_ref),
        .out_timestamp(out_timestamp), .out_misc(out_misc),
        .occupancy(occupancy), .full(full), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill16(input logic [63:0] base);
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid     = 1'b1;
            in_order_ref = base + 64'(i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    logic [63:0] exp_ref;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_type = 4'd0; in_order_ref = 64'd0; in_side = 1'b0; in_shares = 32'd0;
        in_price = 32'd0; in_new_ref = 64'd0; in_timestamp = 48'd0; in_misc = 64'd0;
        #1;
        tick(); tick();
        rst = 1'b0;
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_occ", 64'(occupancy), 64'd0);
        check_eq("rst_full", 64'(full), 64'd0);
        check_eq("rst_ovf", 64'(overflow), 64'd0);
        check_eq("rst_drop", 64'(drop_count), 64'd0);
        check_eq("rst_ref", out_order_ref, 64'd0);

        // 1: single push, held with out_ready low
        in_valid = 1'b1; in_type = 4'd1; in_order_ref = 64'h1234; in_side = 1'b1;
        in_shares = 32'd100; in_price = 32'h000F4240; in_new_ref = 64'h55;
        in_timestamp = 48'hABCDEF012345; in_misc = 64'hCAFEF00D;
        tick();
        in_valid = 1'b0; in_type = 4'd0; in_order_ref = 64'hDEAD;
        check_eq("t1_valid", 64'(out_valid), 64'd1);
        check_eq("t1_occ", 64'(occupancy), 64'd1);
        check_eq("t1_type", 64'(out_type), 64'd1);
        check_eq("t1_ref", out_order_ref, 64'h1234);
        check_eq("t1_side", 64'(out_side), 64'd1);
        check_eq("t1_shares", 64'(out_shares), 64'd100);
        check_eq("t1_price", 64'(out_price), 64'h000F4240);
        check_eq("t1_newref", out_new_ref, 64'h55);
        check_eq("t1_ts", 64'(out_timestamp), 64'hABCDEF012345);
        check_eq("t1_misc", out_misc, 64'hCAFEF00D);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("t1_hold_ref", out_order_ref, 64'h1234);
            check_eq("t1_hold_occ", 64'(occupancy), 64'd1);
        end
        out_ready = 1'b1;
        tick();
        check_eq("t1_pop_valid", 64'(out_valid), 64'd0);
        tick();
        check_eq("t1_empty_pop_occ", 64'(occupancy), 64'd0);

        // 2: fill, drop the 17th, drain in order
        fill16(64'd0);
        check_eq("t2_full", 64'(full), 64'd1);
        check_eq("t2_occ", 64'(occupancy), 64'd16);
        check_eq("t2_head", out_order_ref, 64'd0);
        in_valid = 1'b1; in_order_ref = 64'd16;
        tick();
        in_valid = 1'b0;
        check_eq("t2_drop", 64'(drop_count), 64'd1);
        check_eq("t2_ovf", 64'(overflow), 64'd1);
        check_eq("t2_occ_after_drop", 64'(occupancy), 64'd16);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_eq("t2_drain_valid", 64'(out_valid), 64'd1);
            check_eq("t2_drain_ref", out_order_ref, 64'(i));
            tick();
        end
        check_eq("t2_drained", 64'(out_valid), 64'd0);

        // 3: push into full FIFO while popping
        fill16(64'h100);
        in_valid = 1'b1; in_order_ref = 64'hAA; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check_eq("t3_occ", 64'(occupancy), 64'd16);
        check_eq("t3_drop", 64'(drop_count), 64'd1);
        for (int i = 0; i < 16; i++) begin
            exp_ref = (i < 15) ? 64'h101 + 64'(i) : 64'hAA;
            check_eq("t3_drain_ref", out_order_ref, exp_ref);
            tick();
        end
        check_eq("t3_drained", 64'(out_valid), 64'd0);

        // 4: streaming push+pop, pointers wrap twice
        out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            in_valid = 1'b1; in_order_ref = 64'h200 + 64'(k);
            tick();
            check_eq("t4_ref", out_order_ref, 64'h200 + 64'(k));
            check_eq("t4_occ", 64'(occupancy), 64'd1);
        end
        in_valid = 1'b0;
        tick();
        check_eq("t4_empty", 64'(occupancy), 64'd0);

        // 5: reset mid-stream during a push
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_order_ref = 64'h300 + 64'(i);
            tick();
        end
        check_eq("t5_occ7", 64'(occupancy), 64'd7);
        rst = 1'b1; in_order_ref = 64'h3FF;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check_eq("t5_valid", 64'(out_valid), 64'd0);
        check_eq("t5_occ", 64'(occupancy), 64'd0);
        check_eq("t5_ovf", 64'(overflow), 64'd0);
        check_eq("t5_drop", 64'(drop_count), 64'd0);
        check_eq("t5_ref", out_order_ref, 64'd0);
        in_valid = 1'b1; in_order_ref = 64'h400;
        tick();
        in_valid = 1'b0;
        check_eq("t5_push_valid", 64'(out_valid), 64'd1);
        check_eq("t5_push_ref", out_order_ref, 64'h400);
        check_eq("t5_push_occ", 64'(occupancy), 64'd1);
        out_ready = 1'b1;
        tick();
        check_eq("t5_alone", 64'(out_valid), 64'd0);

        // 6: drop counter saturation
        fill16(64'h500);
        in_valid = 1'b1; in_order_ref = 64'hBAD;
        for (int i = 1; i <= 32'h0000FFFF + 3; i++) begin
            tick();
            if (i == 32'h0000FFFE) begin
                check_eq("t6_below_sat", 64'(drop_count), 64'hFFFE);
            end
        end
        in_valid = 1'b0;
        check_eq("t6_sat", 64'(drop_count), 64'hFFFF);
        check_eq("t6_ovf", 64'(overflow), 64'd1);
        check_eq("t6_occ", 64'(occupancy), 64'd16);
        check_eq("t6_head", out_order_ref, 64'h500);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
